// File: rtl/avg_pkg.sv
// Shared types for the sample collector and the average_calculator datapath.
// Sample width, group size and the quad record used by wrappers and benches.
package avg_pkg;

  localparam int DATA_W = 8;
  localparam int QUAD_N = 4;

  typedef logic [DATA_W-1:0] sample_t;

  typedef struct packed {
    sample_t a;
    sample_t b;
    sample_t c;
    sample_t d;
  } quad_t;

  // Fill index of the collect buffer; FILL3 means the next sample completes a quad.
  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    FILL3 = 2'd3
  } fill_state_t;

  function automatic fill_state_t next_fill(input fill_state_t s);
    return fill_state_t'(s + 2'd1);
  endfunction

endpackage

// File: rtl/sample_quad_collector_quad_out_reg.sv
// Valid/ready output register for one quad plus the handoff counter.
// A new quad may be loaded in the same cycle the held one is taken.
module quad_out_reg
  import avg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data [QUAD_N],
  input  logic              out_ready,
  output logic              out_free,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_c,
  output logic [DATA_W-1:0] out_d,
  output logic [CNT_W-1:0]  group_cnt
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg [QUAD_N];
  logic [CNT_W-1:0]  cnt_reg;
  logic              handoff;

  assign handoff  = valid_reg && out_ready;
  assign out_free = !valid_reg || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
    end else if (handoff) begin
      valid_reg <= 1'b0;
    end
  end

  // The collector only loads when out_free, so the held quad is never overwritten.
  for (genvar gi = 0; gi < QUAD_N; gi++) begin : g_field
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_reg[gi] <= '0;
      end else if (load) begin
        data_reg[gi] <= load_data[gi];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (handoff) begin
      cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = valid_reg;
  assign out_a     = data_reg[0];
  assign out_b     = data_reg[1];
  assign out_c     = data_reg[2];
  assign out_d     = data_reg[3];
  assign group_cnt = cnt_reg;

endmodule

// File: rtl/sample_quad_collector.sv
// Groups a serial sample stream into quads for the averager.
// Three collect slots fill while the output register waits for its consumer.
module sample_quad_collector
  import avg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_c,
  output logic [DATA_W-1:0] out_d,
  output logic [CNT_W-1:0]  group_cnt
);

  fill_state_t       state_reg;
  fill_state_t       state_next;
  logic [DATA_W-1:0] slot_reg [QUAD_N-1];
  logic [DATA_W-1:0] load_data [QUAD_N];
  logic              out_free;
  logic              in_fire;
  logic              keep;
  logic              launch;

  assign in_ready = (state_reg != FILL3) || out_free;
  assign in_fire  = in_valid && in_ready;
  // A sample accepted while flushing is dropped along with the partial group.
  assign keep     = in_fire && !in_flush;
  assign launch   = keep && (state_reg == FILL3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FILL0;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (in_flush) begin
      state_next = FILL0;
    end else if (in_fire) begin
      state_next = next_fill(state_reg);
    end
  end

  for (genvar gi = 0; gi < QUAD_N - 1; gi++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_reg[gi] <= '0;
      end else if (keep && (state_reg == fill_state_t'(2'(gi)))) begin
        slot_reg[gi] <= in_data;
      end
    end
    assign load_data[gi] = slot_reg[gi];
  end

  // The newest sample bypasses the slots straight into the output register.
  assign load_data[QUAD_N-1] = in_data;

  quad_out_reg #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (launch),
    .load_data (load_data),
    .out_ready (out_ready),
    .out_free  (out_free),
    .out_valid (out_valid),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .group_cnt (group_cnt)
  );

endmodule

// File: tb/tb_sample_quad_collector.sv
// Scoreboard bench for sample_quad_collector: directed streams, backpressure,
// flush, async reset and counter wrap (counter narrowed to 4 bits).
module tb_sample_quad_collector;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_a, out_b, out_c, out_d;
  logic [CNT_W-1:0]  group_cnt;

  sample_quad_collector #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_flush  (in_flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .group_cnt (group_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int c;
    int d;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_cnt = 0;
  int   stalls = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) begin
      n_pass++;
      $display("check %-18s actual=%0d required=%0d ok", name, act, req);
    end else begin
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_quad(input int a, input int b, input int c, input int d);
    exp_t e;
    e.a = a; e.b = b; e.c = c; e.d = d;
    e.cnt = exp_cnt % (1 << CNT_W);
    exp_cnt++;
    exp_q.push_back(e);
  endtask

  // Holds in_valid/in_data until accepted; leaves in_valid high on return.
  task automatic send(input int v);
    bit ok;
    in_valid = 1'b1;
    in_data  = DATA_W'(v);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) return;
      stalls++;
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per handoff, and checks held quads stay put.
  logic             hold_vld = 1'b0;
  logic [4*DATA_W-1:0] hold_q;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      hold_vld <= 1'b0;
      if (exp_q.size() == 0) begin
        chk("unexpected_quad", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        pop_cyc.push_back(cyc);
        chk("quad_a", int'(out_a), e.a);
        chk("quad_b", int'(out_b), e.b);
        chk("quad_c", int'(out_c), e.c);
        chk("quad_d", int'(out_d), e.d);
        chk("cnt_at_handoff", int'(group_cnt), e.cnt);
      end
    end else if (rst_n && out_valid) begin
      if (hold_vld) chk("hold_stable", int'({out_a, out_b, out_c, out_d}), int'(hold_q));
      hold_vld <= 1'b1;
      hold_q   <= {out_a, out_b, out_c, out_d};
    end else begin
      hold_vld <= 1'b0;
    end
  end

  initial begin
    int s0;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'({out_a, out_b, out_c, out_d}), 0);
    chk("rst_group_cnt", int'(group_cnt), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Basic quad and latency
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_quad(10, 20, 30, 40);
    send(10); send(20); send(30); send(40);
    in_valid = 1'b0;
    chk("latency_valid", int'(out_valid), 1);
    chk("avg", (int'(out_a) + int'(out_b) + int'(out_c) + int'(out_d)) / 4, 25);
    drain();
    chk("cnt_after_t1", int'(group_cnt), 1);

    // Continuous stream at full rate
    stalls = 0;
    push_quad(100, 150, 200, 250);
    push_quad(0, 0, 0, 0);
    send(100); send(150); send(200); send(250);
    send(0); send(0); send(0); send(0);
    in_valid = 1'b0;
    chk("stream_stalls", stalls, 0);
    drain();
    chk("stream_gap", pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2], 4);
    chk("cnt_after_t2", int'(group_cnt), 3);

    // Backpressure
    out_ready = 1'b0;
    stalls = 0;
    push_quad(255, 255, 255, 255);
    push_quad(255, 255, 255, 255);
    send(255); send(255); send(255); send(255);
    send(255); send(255); send(255);
    chk("bp_stalls", stalls, 0);
    in_data = 8'd255;
    repeat (2) begin
      @(negedge clk);
      chk("bp_in_ready_low", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_back", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_no_bubble", int'(out_valid), 1);
    drain();
    chk("cnt_after_t3", int'(group_cnt), 5);

    // Flush mid-group and at idx=3
    send(1); send(2);
    in_data = 8'd3; in_flush = 1'b1;
    @(posedge clk); #1;
    in_flush = 1'b0; in_valid = 1'b0;
    push_quad(4, 5, 6, 7);
    send4(4, 5, 6, 7);
    send(8); send(9); send(10);
    in_data = 8'd11; in_flush = 1'b1;
    @(posedge clk); #1;
    in_flush = 1'b0; in_valid = 1'b0;
    chk("flush3_no_launch", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("flush3_still_idle", int'(out_valid), 0);
    push_quad(12, 13, 14, 15);
    send4(12, 13, 14, 15);
    drain();
    chk("cnt_after_t4", int'(group_cnt), 7);

    // Asynchronous reset with a pending quad and a partial group
    out_ready = 1'b0;
    send4(1, 2, 3, 4);
    send(5); send(6);
    in_valid = 1'b0;
    chk("pre_rst_valid", int'(out_valid), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_data", int'({out_a, out_b, out_c, out_d}), 0);
    chk("arst_group_cnt", int'(group_cnt), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    exp_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_quad(9, 9, 9, 9);
    send4(9, 9, 9, 9);
    drain();
    chk("cnt_after_t5", int'(group_cnt), 1);

    // Counter wrap
    for (int i = 0; i < 14; i++) begin
      s0 = (i * 7) & 8'hff;
      push_quad(s0, s0 + 1, s0 + 2, s0 + 3);
      send(s0); send(s0 + 1); send(s0 + 2); send(s0 + 3);
    end
    in_valid = 1'b0;
    drain();
    chk("cnt_max", int'(group_cnt), 15);
    push_quad(200, 201, 202, 203);
    send4(200, 201, 202, 203);
    drain();
    chk("cnt_wrap", int'(group_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1);
  end

endmodule
